alu_issue: RTL and testbench
============================

# alu_issue

Registered issue stage between instruction decode and the ALU. Accepts one instruction per cycle with its register-file operands, decodes opcode/funct into the ALU's 6-bit `ALUFun` and `Sign` controls and builds operands A/B. Shift amount goes in A; immediates, zero or `lui` constants go in B. Holds the result in a two-entry skid buffer with valid/ready handshakes on both sides. This lets the pipeline stall without losing throughput.

## Interface
- `DEPTH`, 2: skid capacity; fixed at 2, not user-changeable.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high.
- `in_valid` input 1: upstream holds a valid instruction.
- `in_ready` output 1: stage can accept; registered.
- `instr` input 32: MIPS instruction word.
- `rs_val` input 32: value of register rs.
- `rt_val` input 32: value of register rt.
- `flush` input 1: synchronous kill of all held entries.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: ALU side consumes head.
- `alu_fun` output 6: ALUFun for head.
- `alu_sign` output 1: Sign for head.
- `alu_a` output 32: operand A.
- `alu_b` output 32: operand B.
- `illegal` output 1: head opcode/funct unsupported.

## Operation
- ALUFun codes:
  - add 000000, sub 000001;
  - and 011000, or 011110, xor 010110, nor 010001;
  - sll 100000, srl 100001, sra 100011;
  - eq 110011, neq 110001, lt 110101, lez 111101, ltz 111011, gtz 111111.
- Sign=1 for add, sub, addi, slt, slti and all branches. Sign=0 otherwise, including addu, subu, addiu, sltu, sltiu, lw, sw, logic and shifts.
- Immediates: andi, ori, xori use zero-extended imm16. All other I-types use sign-extended imm16.
- R-type (opcode 0x00), A=rs_val and B=rt_val unless noted:
  - add/addu (0x20/0x21) → add; sub/subu (0x22/0x23) → sub;
  - and, or, xor, nor (0x24–0x27) → matching logic code;
  - slt/sltu (0x2A/0x2B) → lt;
  - sll/srl/sra (0x00/0x02/0x03) → matching shift code, with A={27'b0,shamt} and B=rt_val;
  - jr/jalr (0x08/0x09) → add, with B=0.
- I-type, A=rs_val:
  - addi/addiu (0x08/0x09) → add, B=imm;
  - slti/sltiu (0x0A/0x0B) → lt, B=imm;
  - andi/ori/xori (0x0C–0x0E) → matching logic code, B=zext imm;
  - lw/sw (0x23/0x2B) → add, B=sext imm;
  - lui (0x0F) → sll, with A=16 and B=zext imm.
- Branches:
  - beq/bne (0x04/0x05) → eq/neq, A=rs_val, B=rt_val;
  - blez (0x06) → lez, bgtz (0x07) → gtz, bltz (opcode 0x01, rt=0) → ltz, each with A=rs_val and B=0.
- Any other encoding: illegal=1, alu_fun=add, A=B=0; the entry still flows through the buffer.
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Storage: head register plus skid register.
  - The head loads directly when empty or popping.
  - Otherwise the new entry goes to the skid.
- in_ready is registered. It is 1 exactly when the skid is empty.
- Ordering is strictly FIFO.

## Timing
- Reset: out_valid=0, illegal=0, alu_fun=0, alu_sign=0, alu_a=0, alu_b=0, both entries empty. in_ready=1 from the first cycle after reset deasserts.
- Latency: an instruction accepted at edge N is presented at the outputs with out_valid=1 after edge N.
- Throughput: 1 per cycle while out_ready=1.
- With out_ready=0:
  - the stage accepts 2 entries, then in_ready=0;
  - the output is stable while out_valid && !out_ready.
- Simultaneous accept and pop:
  - skid non-empty: skid moves to the head and the new entry goes to the skid;
  - skid empty: the new entry goes to the head.
- flush at edge N: both entries invalid and out_valid=0 after edge N, with in_ready=1. An accept in the same cycle is dropped. flush has priority over accept and pop.
- Reset asserted mid-stream: immediate clear, asynchronously, to the reset values.

## Structure
- `alu_pkg`: ALUFun localparams, opcode and funct constants, and an `issue_entry` struct {fun, sign, a, b, illegal}.
- Sub-module `alu_ctrl_decode`: purely combinational decode (instr, rs_val, rt_val → issue_entry). `alu_issue` holds the skid/handshake logic only.

## Test plan
- `instr=0x2008FFFF` (addi), rs_val=0 → one cycle later alu_fun=000000, sign=1, A=0, B=0xFFFFFFFF, illegal=0.
- `instr=0x00094100` (sll rt=9, shamt=4), rt_val=0x0000000F → alu_fun=100000, sign=0, A=4, B=0x0000000F.
- `instr=0x3C081234` (lui) → alu_fun=100000, A=16, B=0x00001234. Then `0x19000003` (blez) with rs_val=5 → alu_fun=111101, sign=1, B=0.
- out_ready=0 and three back-to-back instructions I0–I2 → in_ready=0 after I1 is accepted and I2 is held off. Then out_ready=1 → I0, I1, I2 are emitted in order with no gap.
- Buffer holding 2 entries, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed and same-cycle entries never appear.
- `instr=0xFC000000` → illegal=1, alu_fun=000000. Asynchronous reset pulse mid-stream → all outputs zero without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: ALUFun codes,
// MIPS opcode/funct values, operand-source selectors and the entry payload.
package alu_pkg;

  // ALUFun codes understood by the downstream ALU
  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Where operand A comes from
  typedef enum logic [1:0] {
    A_ZERO,
    A_RS,
    A_SHAMT,
    A_SIXTEEN
  } a_sel_e;

  // Where operand B comes from
  typedef enum logic [1:0] {
    B_ZERO,
    B_RT,
    B_SEXT,
    B_ZEXT
  } b_sel_e;

  // One decoded instruction as held in the skid buffer
  typedef struct packed {
    logic [5:0]  fun;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        illegal;
  } issue_entry;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of a MIPS instruction into ALU controls and operands.
// Unsupported encodings produce an add of zero with the illegal flag set.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output issue_entry  entry
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_field;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_rs_field;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign rt_field = instr[20:16];
  assign shamt    = instr[10:6];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};
  // The rs register number is resolved upstream; only its value is used here.
  assign unused_rs_field = ^instr[25:21];

  logic [5:0] fun;
  logic       sign;
  logic       legal;
  a_sel_e     a_sel;
  b_sel_e     b_sel;

  // Classify the instruction into ALU function, sign mode and operand sources
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    fun   = ALU_ADD;
    sign  = 1'b0;
    legal = 1'b1;
    a_sel = A_RS;
    b_sel = B_ZERO;
    case (opcode)
      OP_RTYPE: begin
        b_sel = B_RT;
        case (funct)
          FN_ADD:  sign = 1'b1;
          FN_ADDU: ;
          FN_SUB:  begin fun = ALU_SUB; sign = 1'b1; end
          FN_SUBU: fun = ALU_SUB;
          FN_AND:  fun = ALU_AND;
          FN_OR:   fun = ALU_OR;
          FN_XOR:  fun = ALU_XOR;
          FN_NOR:  fun = ALU_NOR;
          FN_SLT:  begin fun = ALU_LT; sign = 1'b1; end
          FN_SLTU: fun = ALU_LT;
          FN_SLL:  begin fun = ALU_SLL; a_sel = A_SHAMT; end
          FN_SRL:  begin fun = ALU_SRL; a_sel = A_SHAMT; end
          FN_SRA:  begin fun = ALU_SRA; a_sel = A_SHAMT; end
          FN_JR, FN_JALR: b_sel = B_ZERO;
          default: legal = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        if (rt_field == 5'd0) begin
          fun  = ALU_LTZ;
          sign = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_BEQ:   begin fun = ALU_EQ;  sign = 1'b1; b_sel = B_RT; end
      OP_BNE:   begin fun = ALU_NEQ; sign = 1'b1; b_sel = B_RT; end
      OP_BLEZ:  begin fun = ALU_LEZ; sign = 1'b1; end
      OP_BGTZ:  begin fun = ALU_GTZ; sign = 1'b1; end
      OP_ADDI:  begin sign = 1'b1; b_sel = B_SEXT; end
      OP_ADDIU: b_sel = B_SEXT;
      OP_SLTI:  begin fun = ALU_LT; sign = 1'b1; b_sel = B_SEXT; end
      OP_SLTIU: begin fun = ALU_LT; b_sel = B_SEXT; end
      OP_ANDI:  begin fun = ALU_AND; b_sel = B_ZEXT; end
      OP_ORI:   begin fun = ALU_OR;  b_sel = B_ZEXT; end
      OP_XORI:  begin fun = ALU_XOR; b_sel = B_ZEXT; end
      OP_LW, OP_SW: b_sel = B_SEXT;
      OP_LUI:   begin fun = ALU_SLL; a_sel = A_SIXTEEN; b_sel = B_ZEXT; end
      default:  legal = 1'b0;
    endcase
    if (!legal) begin
      fun   = ALU_ADD;
      sign  = 1'b0;
      a_sel = A_ZERO;
      b_sel = B_ZERO;
    end
  end

  // Build the operands from the selected sources and pack the entry
  always_comb begin
    entry = '0;
    case (a_sel)
      A_RS:      entry.a = rs_val;
      A_SHAMT:   entry.a = {27'd0, shamt};
      A_SIXTEEN: entry.a = 32'd16;
      default:   entry.a = 32'd0;
    endcase
    case (b_sel)
      B_RT:    entry.b = rt_val;
      B_SEXT:  entry.b = imm_sext;
      B_ZEXT:  entry.b = imm_zext;
      default: entry.b = 32'd0;
    endcase
    entry.fun     = fun;
    entry.sign    = sign;
    entry.illegal = ~legal;
  end

endmodule

// File: rtl/alu_issue.sv
// Registered issue stage in front of the ALU: decodes one instruction per
// cycle and holds results in a head + skid buffer with valid/ready on both sides.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        illegal
);

  // Skid capacity: head plus one skid slot
  localparam logic [1:0] DEPTH = 2'd2;

  issue_entry dec_entry;

  issue_entry head_q, head_d;
  issue_entry skid_q, skid_d;
  logic       head_valid_q, head_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_ready_q, in_ready_d;

  logic       accept;
  logic       pop;
  logic [1:0] occupancy_d;

  alu_ctrl_decode u_decode (
    .instr  (instr),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .entry  (dec_entry)
  );

  assign accept = in_valid && in_ready_q;
  assign pop    = head_valid_q && out_ready;

  // Next-state of the head/skid pair: flush wins, then refill head, else park in skid
  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q || pop) begin
      if (skid_valid_q) begin
        head_d       = skid_q;
        head_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) begin
          skid_d = dec_entry;
        end
      end else begin
        head_valid_d = accept;
        if (accept) begin
          head_d = dec_entry;
        end
      end
    end else if (accept) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
    occupancy_d = {1'b0, head_valid_d} + {1'b0, skid_valid_d};
    // Room for one more exactly when the skid slot will be free
    in_ready_d  = (occupancy_d < DEPTH);
  end

  // State registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: payload registers are reset as well because the outputs must read zero in reset.
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = head_valid_q;
  assign alu_fun   = head_q.fun;
  assign alu_sign  = head_q.sign;
  assign alu_a     = head_q.a;
  assign alu_b     = head_q.b;
  assign illegal   = head_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed decode cases, back-pressure,
// flush, illegal encodings, async reset and a randomized run against a queue model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        illegal;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [5:0] F_ADD = 6'b000000, F_SUB = 6'b000001, F_AND = 6'b011000,
                         F_OR  = 6'b011110, F_XOR = 6'b010110, F_NOR = 6'b010001,
                         F_SLL = 6'b100000, F_SRL = 6'b100001, F_SRA = 6'b100011,
                         F_EQ  = 6'b110011, F_NEQ = 6'b110001, F_LT  = 6'b110101,
                         F_LEZ = 6'b111101, F_LTZ = 6'b111011, F_GTZ = 6'b111111;

  localparam logic [5:0] OPS [16] = '{6'h00, 6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                                      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23};
  localparam logic [5:0] FNS [16] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
                                      6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h2B};

  typedef struct {
    logic [5:0]  fun;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  // Entries accepted and not yet consumed, oldest first
  exp_t mq[$];

  wire [72:0] obs = {out_valid, alu_fun, alu_sign, alu_a, alu_b, illegal};

  alu_issue dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_fun   (alu_fun),
    .alu_sign  (alu_sign),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [5:0] f, input logic s,
                              input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    r = '{f, s, a, b, 1'b0};
    return r;
  endfunction

  // What the ALU should be told for one instruction, straight from the ISA table
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] rs,
                                      input logic [31:0] rt);
    logic [31:0] se, ze, sh;
    exp_t r;
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'h0, w[15:0]};
    sh = {27'd0, w[10:6]};
    r  = '{F_ADD, 1'b0, 32'd0, 32'd0, 1'b1};
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h20: r = mk(F_ADD, 1, rs, rt);
        6'h21: r = mk(F_ADD, 0, rs, rt);
        6'h22: r = mk(F_SUB, 1, rs, rt);
        6'h23: r = mk(F_SUB, 0, rs, rt);
        6'h24: r = mk(F_AND, 0, rs, rt);
        6'h25: r = mk(F_OR,  0, rs, rt);
        6'h26: r = mk(F_XOR, 0, rs, rt);
        6'h27: r = mk(F_NOR, 0, rs, rt);
        6'h2A: r = mk(F_LT,  1, rs, rt);
        6'h2B: r = mk(F_LT,  0, rs, rt);
        6'h00: r = mk(F_SLL, 0, sh, rt);
        6'h02: r = mk(F_SRL, 0, sh, rt);
        6'h03: r = mk(F_SRA, 0, sh, rt);
        6'h08, 6'h09: r = mk(F_ADD, 0, rs, 32'd0);
        default: ;
      endcase
      6'h01: if (w[20:16] == 5'd0) r = mk(F_LTZ, 1, rs, 32'd0);
      6'h04: r = mk(F_EQ,  1, rs, rt);
      6'h05: r = mk(F_NEQ, 1, rs, rt);
      6'h06: r = mk(F_LEZ, 1, rs, 32'd0);
      6'h07: r = mk(F_GTZ, 1, rs, 32'd0);
      6'h08: r = mk(F_ADD, 1, rs, se);
      6'h09: r = mk(F_ADD, 0, rs, se);
      6'h0A: r = mk(F_LT,  1, rs, se);
      6'h0B: r = mk(F_LT,  0, rs, se);
      6'h0C: r = mk(F_AND, 0, rs, ze);
      6'h0D: r = mk(F_OR,  0, rs, ze);
      6'h0E: r = mk(F_XOR, 0, rs, ze);
      6'h0F: r = mk(F_SLL, 0, 32'd16, ze);
      6'h23, 6'h2B: r = mk(F_ADD, 0, rs, se);
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [72:0] pk(input exp_t e);
    return {1'b1, e.fun, e.sign, e.a, e.b, e.ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4) begin
      w[31:26] = 6'h00;
      w[5:0]   = (k == 0) ? 6'($urandom) : FNS[$urandom_range(0, 15)];
    end else if (k == 4) begin
      w[31:26] = 6'h01;
      if ($urandom_range(0, 1) == 0) w[20:16] = 5'd0;
    end else if (k < 9) begin
      w[31:26] = OPS[$urandom_range(0, 15)];
    end
    return w;
  endfunction

  // One clock edge; the model applies flush / pop / accept with the pre-edge inputs
  task automatic tick();
    bit acc, pop;
    acc = in_valid && (mq.size() < 2);
    pop = (mq.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(ref_decode(instr, rs_val, rt_val));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    instr = 32'd0; rs_val = 32'd0; rt_val = 32'd0;
    #12;
    n_total++;
    if (obs !== 73'd0) $display("FAIL reset_outputs: got %h expected %h", obs, 73'd0);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_ready: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_decode();
    out_ready = 1'b1; in_valid = 1'b1;
    instr = 32'h2008FFFF; rs_val = 32'd0; rt_val = 32'h12345678;
    tick();
    n_total++;
    if (obs !== {1'b1, 6'b000000, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b0})
      $display("FAIL addi: got %h", obs);
    else n_pass++;
    instr = 32'h00094100; rs_val = 32'hDEADBEEF; rt_val = 32'h0000000F;
    tick();
    n_total++;
    if (obs !== {1'b1, 6'b100000, 1'b0, 32'd4, 32'h0000000F, 1'b0})
      $display("FAIL sll: got %h", obs);
    else n_pass++;
    instr = 32'h3C081234; rs_val = 32'hAAAA5555;
    tick();
    n_total++;
    if (obs !== {1'b1, 6'b100000, 1'b0, 32'd16, 32'h00001234, 1'b0})
      $display("FAIL lui: got %h", obs);
    else n_pass++;
    instr = 32'h19000003; rs_val = 32'd5; rt_val = 32'd77;
    tick();
    n_total++;
    if (obs !== {1'b1, 6'b111101, 1'b1, 32'd5, 32'd0, 1'b0})
      $display("FAIL blez: got %h", obs);
    else n_pass++;
    in_valid = 1'b0;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL drain: got out_valid=%b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; rs_val = 32'd0;
    instr = 32'h20080001; tick();
    instr = 32'h20080002; tick();
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL full_ready: got %b expected 0", in_ready);
    else n_pass++;
    instr = 32'h20080003; tick();
    n_total++;
    if (in_ready !== 1'b0 || alu_b !== 32'd1 || out_valid !== 1'b1)
      $display("FAIL held_head: got ready=%b valid=%b b=%h expected 0/1/1", in_ready, out_valid, alu_b);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++;
    if (out_valid !== 1'b1 || alu_b !== 32'd2)
      $display("FAIL emit_i1: got valid=%b b=%h expected 1/2", out_valid, alu_b);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || alu_b !== 32'd3)
      $display("FAIL emit_i2: got valid=%b b=%h expected 1/3", out_valid, alu_b);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || mq.size() != 0)
      $display("FAIL b2b_empty: got valid=%b model=%0d expected 0/0", out_valid, mq.size());
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; rs_val = 32'd0;
    instr = 32'h20080011; tick();
    instr = 32'h20080022; tick();
    flush = 1'b1; instr = 32'h20080033; tick();
    flush = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_state: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    else n_pass++;
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL flush_ghost: got out_valid=%b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1;
    instr = 32'hFC000000; rs_val = 32'h11111111; rt_val = 32'h22222222;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (obs !== {1'b1, 6'b000000, 1'b0, 32'd0, 32'd0, 1'b1})
      $display("FAIL illegal: got %h", obs);
    else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h00431020; rs_val = 32'h00000123; rt_val = 32'h00000456;
    tick();
    instr = 32'h30A5FFFF; tick();
    in_valid = 1'b0;
    n_total++;
    if (mq.size() == 0 || obs !== pk(mq[0]))
      $display("FAIL pre_reset: got %h model_size=%0d", obs, mq.size());
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    mq.delete();
    n_total++;
    if (obs !== 73'd0 || in_ready !== 1'b1)
      $display("FAIL async_reset: got %h ready=%b expected 0/1", obs, in_ready);
    else n_pass++;
    #3 reset = 1'b0;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL post_reset: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      instr     = rand_instr();
      rs_val    = $urandom;
      rt_val    = $urandom;
      tick();
      n_total++;
      if (in_ready !== 1'(mq.size() < 2))
        $display("FAIL rand_ready[%0d]: got %b model_size=%0d", i, in_ready, mq.size());
      else n_pass++;
      n_total++;
      if (mq.size() > 0) begin
        if (obs !== pk(mq[0])) $display("FAIL rand_head[%0d]: got %h expected %h", i, obs, pk(mq[0]));
        else n_pass++;
      end else begin
        if (out_valid !== 1'b0) $display("FAIL rand_empty[%0d]: got out_valid=%b expected 0", i, out_valid);
        else n_pass++;
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
